// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial bit-pattern detector with
// match counting, overlap control and auto-stop at a target count.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_target,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  input  logic                     in,
  output logic                     out,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         match_count
);

  localparam int LW = $clog2(MAX_LEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_tgt;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out;

  logic [LW-1:0]      w_len_cl;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic [LW-1:0]      w_fill_inc;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_sample;
  logic               w_match;
  logic               w_restart;
  logic               w_to_done;
  logic [1:0]         w_state_nxt;

  always_comb begin
    w_len_cl = cfg_len;
    if (cfg_len < LW'(2))
      w_len_cl = LW'(2);
    else if (cfg_len > LW'(MAX_LEN))
      w_len_cl = LW'(MAX_LEN);
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_sample   = (r_state == S_RUN) && in_valid;
  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_inc = (r_fill == LW'(MAX_LEN)) ? r_fill
                                               : r_fill + 1'b1;

  // Fill must cover the pattern so stale history never matches.
  assign w_match = w_sample
                && (w_fill_inc >= r_len)
                && ((w_hist_nxt & w_mask) == (r_pat & w_mask));

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  assign w_restart = start && !stop
                  && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_to_done = w_match && !stop
                  && (r_tgt != '0) && (w_cnt_inc == r_tgt);

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      stop:      w_state_nxt = S_IDLE;
      w_restart: w_state_nxt = S_RUN;
      w_to_done: w_state_nxt = S_DONE;
      default:   w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pat   <= MAX_LEN'(3'b101);
      r_len   <= LW'(3);
      r_ovl   <= 1'b1;
      r_tgt   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_match;
      if ((r_state == S_IDLE) && cfg_we) begin
        r_pat <= cfg_pattern;
        r_len <= w_len_cl;
        r_ovl <= cfg_overlap;
        r_tgt <= cfg_target;
      end
      if (w_restart) begin
        r_hist <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
      end else if (w_sample) begin
        r_hist <= w_hist_nxt;
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
        if (w_match)
          r_cnt <= w_cnt_inc;
      end
    end
  end

  assign out         = r_out;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed steps plus random traffic
// checked against a queue-based behavioural model.
module tb_seq_detect_ctrl;

  localparam int ML = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [3:0]    cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic [CW-1:0] cfg_target = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in = 1'b0;
  logic          out;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_count;

  logic          b_cfg_we = 1'b0;
  logic [ML-1:0] b_cfg_pattern = '0;
  logic [3:0]    b_cfg_len = '0;
  logic          b_cfg_overlap = 1'b0;
  logic [1:0]    b_cfg_target = '0;
  logic          b_start = 1'b0;
  logic          b_stop = 1'b0;
  logic          b_in_valid = 1'b0;
  logic          b_in = 1'b0;
  logic          b_out;
  logic          b_busy;
  logic          b_done;
  logic [1:0]    b_match_count;

  int total = 0;
  int bad = 0;

  // reference model state
  int       m_st;
  bit       m_q[$];
  int       m_cnt;
  bit       m_out;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_tgt;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .in_valid(in_valid), .in(in),
    .out(out), .busy(busy), .done(done),
    .match_count(match_count)
  );

  seq_detect_ctrl #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(b_cfg_we),
    .cfg_pattern(b_cfg_pattern), .cfg_len(b_cfg_len),
    .cfg_overlap(b_cfg_overlap), .cfg_target(b_cfg_target),
    .start(b_start), .stop(b_stop), .in_valid(b_in_valid),
    .in(b_in), .out(b_out), .busy(b_busy), .done(b_done),
    .match_count(b_match_count)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit hit;
    int n;
    hit = 1'b0;
    if (!reset) begin
      m_st = 0; m_q.delete(); m_cnt = 0; m_out = 1'b0;
      m_pat = 8'b101; m_len = 3; m_ovl = 1'b1; m_tgt = 0;
      return;
    end
    if (m_st == 1 && in_valid) begin
      m_q.push_back(in);
      if (m_q.size() > ML) void'(m_q.pop_front());
      n = m_q.size();
      if (n >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_q[n-1-i] != m_pat[i]) hit = 1'b0;
      end
      if (hit) begin
        if (!m_ovl) m_q.delete();
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_out = hit;
    case (m_st)
      0: begin
        if (cfg_we) begin
          m_pat = cfg_pattern;
          m_len = (cfg_len < 2) ? 2 : (cfg_len > ML) ? ML : int'(cfg_len);
          m_ovl = cfg_overlap;
          m_tgt = int'(cfg_target);
        end
        if (!stop && start) begin m_st = 1; m_q.delete(); m_cnt = 0; end
      end
      1: begin
        if (stop) m_st = 0;
        else if (hit && m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
      end
      default: begin
        if (stop) m_st = 0;
        else if (start) begin m_st = 1; m_q.delete(); m_cnt = 0; end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("count", 32'(match_count), 32'(m_cnt));
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0; b_start = 1'b0;
  endtask

  task automatic bitin(logic v, logic b);
    in_valid = v; in = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
  endtask

  task automatic cfg(logic [7:0] p, logic [3:0] l, logic o, logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
    cfg_overlap = o; cfg_target = t;
    tick();
  endtask

  initial begin
    // reset defaults
    reset = 1'b0;
    tick(); tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(match_count), 0);
    reset = 1'b1;

    // overlapped 101
    do_start();
    bitin(1, 1); bitin(1, 0); bitin(1, 1);
    chk("t1_pulse3", 32'(out), 1);
    bitin(1, 0); bitin(1, 1);
    chk("t1_pulse5", 32'(out), 1);
    tick();
    chk("t1_count", 32'(match_count), 2);
    do_stop();

    // non-overlapped 101
    cfg(8'b101, 4'd3, 1'b0, 8'd0);
    do_start();
    bitin(1, 1); bitin(1, 0); bitin(1, 1); bitin(1, 0); bitin(1, 1);
    tick();
    chk("t2_count", 32'(match_count), 1);
    do_stop();

    // 1101 with target 2
    cfg(8'b1101, 4'd4, 1'b1, 8'd2);
    do_start();
    bitin(1, 1); bitin(1, 1); bitin(1, 0); bitin(1, 1);
    bitin(1, 1); bitin(1, 0); bitin(1, 1);
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    bitin(1, 1); bitin(1, 0); bitin(1, 1);
    tick();
    chk("t3_count", 32'(match_count), 2);
    do_stop();

    // gaps are transparent
    cfg(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    bitin(1, 1); bitin(0, 0); bitin(0, 0); bitin(0, 0);
    bitin(1, 0); bitin(0, 1); bitin(1, 1);
    chk("t4_pulse", 32'(out), 1);
    tick();
    chk("t4_count", 32'(match_count), 1);
    do_stop();

    // cfg in RUN ignored
    do_start();
    cfg(8'b11, 4'd2, 1'b1, 8'd0);
    bitin(1, 1); bitin(1, 0); bitin(1, 1);
    tick();
    chk("t5_cfg_ign", 32'(match_count), 1);
    start = 1'b1; stop = 1'b1;
    tick();
    chk("t5_stop_win", 32'(busy), 0);

    // reset mid-run restores defaults
    cfg(8'b11, 4'd2, 1'b1, 8'd0);
    do_start();
    bitin(1, 1); bitin(1, 1);
    reset = 1'b0;
    tick();
    chk("t5_rst_out", 32'(out), 0);
    chk("t5_rst_cnt", 32'(match_count), 0);
    reset = 1'b1;
    do_start();
    bitin(1, 1); bitin(1, 0); bitin(1, 1); bitin(1, 0); bitin(1, 1);
    tick();
    chk("t5_rst_pat", 32'(match_count), 2);
    do_stop();

    // len 0 clamps to 2
    cfg(8'b10, 4'd0, 1'b1, 8'd0);
    do_start();
    bitin(1, 1); bitin(1, 0); bitin(1, 1); bitin(1, 0);
    tick();
    chk("t6_len0", 32'(match_count), 2);
    do_stop();

    // 2-bit counter saturates
    b_start = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      b_in_valid = 1'b1; b_in = (i % 2 == 0);
      tick();
    end
    b_in_valid = 1'b0;
    tick();
    chk("t6_sat", 32'(b_match_count), 3);
    chk("t6_sat_busy", 32'(b_busy), 1);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      reset       = ($urandom_range(0, 199) != 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom);
      cfg_target  = 8'($urandom_range(0, 4));
      in_valid    = ($urandom_range(0, 3) != 0);
      in          = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Configurable controller for the team's serial bit-pattern detectors. It holds a programmable pattern, length and overlap mode, and runs detection on a qualified serial bit stream. It counts matches and stops automatically when a target count is reached. It sits between a host/config interface and the serial input; after reset it behaves as a "101" Moore detector with overlap.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
cfg_we  input  1  config write strobe, honoured only in IDLE
cfg_pattern  input  MAX_LEN  pattern; bit 0 = most recently received bit
cfg_len  input  $clog2(MAX_LEN)+1  pattern length in bits
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  match count that ends the run; 0 = unlimited
start  input  1  begin run (IDLE or DONE)
stop  input  1  abort run
in_valid  input  1  qualifies in
in  input  1  serial data bit
out  output  1  one-cycle match pulse (registered, Moore)
busy  output  1  high in RUN
done  output  1  high in DONE
match_count  output  CNT_W  matches in current/last run

Behaviour:
- Reset (reset==0 at clk edge) gives these values:
  - State IDLE; out=0, busy=0, done=0, match_count=0.
  - History and fill counter cleared.
  - Config registers: pattern='b101, len=3, overlap=1, target=0.
  - Reset mid-run aborts with no further pulses.
- Config:
  - cfg_we in IDLE latches all cfg_* on that edge. cfg_we in RUN/DONE is ignored.
  - len is clamped: 0 or 1 → 2; >MAX_LEN → MAX_LEN.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start. This clears history, fill counter and match_count.
  - RUN → IDLE on stop. match_count is held.
  - RUN → DONE in the cycle after match_count reaches a nonzero target.
  - DONE → RUN on start, with the same clearing as from IDLE. DONE → IDLE on stop.
  - start and stop in the same cycle: stop wins.
  - start in RUN is ignored.
- Detection (RUN only; in_valid=1 samples in):
  - hist <= {hist[MAX_LEN-2:0], in}.
  - fill <= min(fill+1, MAX_LEN).
  - A match occurs when the new fill >= len and the new low len bits of hist equal pattern[len-1:0].
  - in_valid=0 holds hist/fill with no match; gaps are transparent.
- Output timing:
  - out=1 for exactly one cycle, the cycle after the edge that sampled the final pattern bit. This is latency 1, Moore style.
  - out is 0 outside RUN, except for a pulse from the last sample in RUN.
- Overlap:
  - overlap=1: history is kept after a match.
  - overlap=0: fill resets to 0 on the match edge, so the next match needs len fresh bits.
- Counter:
  - match_count increments on each match edge and saturates at 2^CNT_W-1.
  - When it reaches a nonzero target, the FSM goes to DONE and later samples are ignored.
  - A match on the same edge as stop is still counted and pulsed.
- Outputs: busy and done decode the registered state.

Test Plan:
1. Reset defaults, start, in stream 1,0,1,0,1 (in_valid=1 every cycle) → out pulses after the 3rd and 5th samples; match_count=2.
2. Same stream, non-overlap (cfg_we in IDLE with pattern='b101, len=3, overlap=0) → single pulse after the 3rd sample; match_count=1.
3. cfg_pattern='b1101, len=4, target=2; stream 1,1,0,1,1,0,1,1,0,1 → pulses after samples 4 and 7; done=1 and busy=0 the next cycle; sample 10 not counted; match_count=2.
4. in_valid gaps: bits 1,(gap 3 cycles),0,(gap),1 with default config → one pulse, 1 cycle after the final valid bit; match_count=1.
5. Mid-run controls:
   - cfg_we in RUN with pattern='b11 → ignored; "101" still detected.
   - stop+start same cycle → IDLE.
   - reset=0 mid-stream → out=0, match_count=0, pattern back to 'b101.
6. cfg_len=0 → behaves as len=2. CNT_W=2 with target=0 and 5 matches → match_count saturates at 3.
